// File: rtl/pc_pkg.sv
// Shared types and default constants for the miniRISC program-counter unit.
package pc_pkg;

    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_MAX_ADDR  = 1000;
    localparam int unsigned DEF_INC_STEP  = 1;
    localparam int unsigned DEF_RAS_DEPTH = 4;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_ADDR = '1;

    typedef enum logic {
        PC_RUN,
        PC_HALTED
    } pc_state_t;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_BR,
        SRC_CALL,
        SRC_RET
    } pc_src_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO. Push on full and pop on empty are ignored.
// A simultaneous push and pop replaces the top entry.
module ras_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    top_idx, wr_idx;
    logic             wr_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign top_idx = IW'(count_q - CW'(1));
    assign count   = count_q;
    assign top     = empty ? '0 : mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = IW'(count_q);
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push && !full) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_unit_rs.sv
// Program-counter unit: next-address select, return-address stack,
// halt/resume control and upper-bound clamping of the fetch address.
module pc_unit_rs
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{DEF_RESET_ADDR[0]}},
    parameter logic [ADDR_W-1:0] MAX_ADDR   = ADDR_W'(DEF_MAX_ADDR),
    parameter int unsigned       INC_STEP   = DEF_INC_STEP,
    parameter int unsigned       RAS_DEPTH  = DEF_RAS_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           branch_en,
    input  logic                           call_en,
    input  logic                           ret_en,
    input  logic [ADDR_W-1:0]              branch_target,
    input  logic                           halt_req,
    input  logic                           resume,
    output logic [ADDR_W-1:0]              pc,
    output logic                           halted,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    pc_state_t         state_q;
    pc_src_t           src;
    logic [ADDR_W-1:0] pc_q, pc_d, nxt, seq_addr, ras_top;
    logic              halted_q, ovf_q, unf_q, ovf_d, unf_d;
    logic              active, ras_push, ras_pop, ras_full, ras_empty;
    logic [CW-1:0]     ras_cnt;

    assign active   = (state_q == PC_RUN) && !halt_req && !stall;
    assign seq_addr = pc_q + ADDR_W'(INC_STEP);

    always_comb begin
        src = SRC_HOLD;
        if (active) begin
            if (ret_en) begin
                src = SRC_RET;
            end else if (call_en) begin
                src = SRC_CALL;
            end else if (branch_en) begin
                src = SRC_BR;
            end else begin
                src = SRC_SEQ;
            end
        end
    end

    always_comb begin
        nxt = pc_q;
        unique case (src)
            SRC_HOLD: nxt = pc_q;
            SRC_SEQ:  nxt = seq_addr;
            SRC_BR:   nxt = branch_target;
            SRC_CALL: nxt = branch_target;
            SRC_RET:  nxt = ras_empty ? seq_addr : ras_top;
            default:  nxt = pc_q;
        endcase
        // A held pc bypasses the clamp so RESET_ADDR survives a stall or halt.
        if (src == SRC_HOLD) begin
            pc_d = pc_q;
        end else begin
            pc_d = (nxt > MAX_ADDR) ? MAX_ADDR : nxt;
        end
    end

    assign ras_push = (src == SRC_CALL);
    assign ras_pop  = (src == SRC_RET);
    assign ovf_d    = (src == SRC_CALL) && ras_full;
    assign unf_d    = (src == SRC_RET) && ras_empty;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (seq_addr),
        .top   (ras_top),
        .count (ras_cnt),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PC_RUN;
            pc_q     <= RESET_ADDR;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            unique case (state_q)
                PC_RUN: begin
                    if (halt_req) begin
                        state_q  <= PC_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                PC_HALTED: begin
                    if (resume && !halt_req) begin
                        state_q  <= PC_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= PC_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc            = pc_q;
    assign halted        = halted_q;
    assign ras_count     = ras_cnt;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule
